// File: rtl/div_unit_pkg.sv
// Shared widths, op codes, FSM encoding and sign helpers for the RV32M divider.
package div_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned RD_W  = 5;
  localparam int unsigned OP_W  = 2;

  localparam logic [OP_W-1:0] OP_DIV  = 2'b00;
  localparam logic [OP_W-1:0] OP_DIVU = 2'b01;
  localparam logic [OP_W-1:0] OP_REM  = 2'b10;
  localparam logic [OP_W-1:0] OP_REMU = 2'b11;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Bit 0 clear selects the signed flavour, bit 1 set selects the remainder.
  function automatic logic op_is_signed(logic [OP_W-1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(logic [OP_W-1:0] op);
    return op[1];
  endfunction

  function automatic logic [XLEN-1:0] neg_if(logic [XLEN-1:0] x, logic neg);
    return neg ? (~x + XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage request/response bundle between pipeline control and the divider.
interface div_unit_if;
  import div_unit_pkg::*;

  logic                 start_i;
  logic [OP_W-1:0]      op_i;
  logic [XLEN-1:0]      dividend_i;
  logic [XLEN-1:0]      divisor_i;
  logic [RD_W-1:0]      rd_addr_i;
  logic                 flush_i;
  logic [XLEN-1:0]      result_o;
  logic [RD_W-1:0]      rd_addr_o;
  logic                 valid_o;
  logic                 stall_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    input  result_o, rd_addr_o, valid_o, stall_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    output result_o, rd_addr_o, valid_o, stall_o
  );

endinterface

// File: rtl/div_core_step.sv
// One restoring-division step: shift {rem, dividend} left, trial-subtract, emit quotient bit.
module div_core_step
  import div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] dvd_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic          fits;

  assign rem_sh = {rem_i, dvd_i[XLEN-1]};
  assign fits   = rem_sh >= {1'b0, dvsr_i};

  // Difference is below the divisor whenever it is kept, so XLEN bits hold it.
  assign rem_o = fits ? XLEN'(rem_sh - {1'b0, dvsr_i}) : rem_sh[XLEN-1:0];
  assign quo_o = {dvd_i[XLEN-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU; stalls the pipe while computing.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  div_unit_if.slave   bus
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_rem_q, is_rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [RD_W-1:0]   rd_addr_q, rd_addr_d;
  logic              valid_q, valid_d;
  logic              stall_c;

  logic              accept_c;
  logic              sgn_c;
  logic              rem_op_c;
  logic              dvd_neg_c;
  logic              dvs_neg_c;
  logic              div_zero_c;
  logic              ovf_c;
  logic              special_c;
  logic              last_c;
  logic [XLEN-1:0]   step_rem_c;
  logic [XLEN-1:0]   step_quo_c;

  // Request decode and special-case detection, looked at only while IDLE.
  assign accept_c   = bus.start_i & ~bus.flush_i;
  assign sgn_c      = op_is_signed(bus.op_i);
  assign rem_op_c   = op_is_rem(bus.op_i);
  assign dvd_neg_c  = sgn_c & bus.dividend_i[XLEN-1];
  assign dvs_neg_c  = sgn_c & bus.divisor_i[XLEN-1];
  assign div_zero_c = (bus.divisor_i == '0);
  assign ovf_c      = sgn_c & (bus.dividend_i == INT_MIN) & (bus.divisor_i == '1);
  assign special_c  = div_zero_c | ovf_c;
  assign last_c     = (cnt_q == CNT_W'(XLEN-1));

  div_core_step u_step (
    .rem_i  (rem_q),
    .dvd_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem_c),
    .quo_o  (step_quo_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = special_c ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (bus.flush_i)  state_d = ST_IDLE;
        else if (last_c)  state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next-values.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    result_d  = result_q;
    rd_addr_d = rd_addr_q;
    valid_d   = 1'b0;
    stall_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          stall_c   = 1'b1;
          rd_addr_d = bus.rd_addr_i;
          is_rem_d  = rem_op_c;
          neg_quo_d = dvd_neg_c ^ dvs_neg_c;
          neg_rem_d = dvd_neg_c;
          if (div_zero_c) begin
            result_d = rem_op_c ? bus.dividend_i : '1;
            valid_d  = 1'b1;
          end else if (ovf_c) begin
            result_d = rem_op_c ? '0 : INT_MIN;
            valid_d  = 1'b1;
          end else begin
            rem_d  = '0;
            quo_d  = neg_if(bus.dividend_i, dvd_neg_c);
            dvsr_d = neg_if(bus.divisor_i, dvs_neg_c);
            cnt_d  = '0;
          end
        end
      end
      ST_CALC: begin
        stall_c = 1'b1;
        if (!bus.flush_i) begin
          rem_d = step_rem_c;
          quo_d = step_quo_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_c) begin
            result_d = is_rem_q ? neg_if(step_rem_c, neg_rem_q)
                                : neg_if(step_quo_c, neg_quo_q);
            valid_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      result_q  <= '0;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      result_q  <= result_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.result_o  = result_q;
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.valid_o   = valid_q;
  assign bus.stall_o   = stall_c;

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit against an arithmetic RV32M reference.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  div_unit_if bus ();

  div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics straight from the ISA rules.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Issue one request at a negedge and follow it to its valid pulse.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit noisy);
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    int          stall_cnt;
    bit          special;
    exp     = ref_model(op, a, b);
    special = (b == 32'd0) || (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    exp_lat = special ? 1 : 33;
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.rd_addr_i  = rd;
    bus.flush_i    = 1'b0;
    bus.start_i    = 1'b1;
    #1;
    stall_cnt = bus.stall_o ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        lat = k;
        break;
      end
      if (bus.stall_o) stall_cnt++;
      if (noisy) begin
        bus.start_i    = 1'($urandom_range(0, 1));
        bus.op_i       = 2'($urandom_range(0, 3));
        bus.dividend_i = $urandom;
        bus.divisor_i  = $urandom;
        bus.rd_addr_i  = 5'($urandom_range(0, 31));
      end else begin
        bus.start_i = 1'b0;
      end
    end
    bus.start_i = 1'b0;
    check($sformatf("latency op%0d", op), 32'(lat), 32'(exp_lat));
    check($sformatf("result op%0d a=%08h b=%08h", op, a, b), bus.result_o, exp);
    check("rd_addr", 32'(bus.rd_addr_o), 32'(rd));
    check("stall_cycles", 32'(stall_cnt), 32'(exp_lat));
    check("stall_in_done", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    check("valid_one_cycle", 32'(bus.valid_o), 32'd0);
  endtask

  task automatic rand_op();
    logic [1:0]  op;
    logic [31:0] a, b;
    int          r;
    op = 2'($urandom_range(0, 3));
    a  = $urandom;
    r  = $urandom_range(0, 7);
    case (r)
      0: b = 32'd0;
      1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
      2: b = 32'($urandom_range(1, 15));
      3: begin a = 32'h8000_0000; b = $urandom; end
      4: begin b = $urandom; a = a >> $urandom_range(0, 31); end
      default: b = $urandom;
    endcase
    run_op(op, a, b, 5'($urandom_range(0, 31)), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    bus.start_i    = 1'b0;
    bus.op_i       = 2'b00;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    bus.rd_addr_i  = '0;
    bus.flush_i    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_result", bus.result_o, 32'd0);
    check("reset_rd", 32'(bus.rd_addr_o), 32'd0);
    check("reset_valid", 32'(bus.valid_o), 32'd0);
    check("reset_stall", 32'(bus.stall_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(OP_DIV,  32'd100,      32'd7,        5'd5,  1'b0);
    run_op(OP_REM,  32'hFFFFFF9C, 32'd7,        5'd6,  1'b0);
    run_op(OP_DIV,  32'hFFFFFF9C, 32'd7,        5'd7,  1'b0);
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'd2,        5'd8,  1'b0);
    run_op(OP_REMU, 32'hFFFFFFFF, 32'd2,        5'd9,  1'b0);
    run_op(OP_DIV,  32'h12345678, 32'd0,        5'd10, 1'b0);
    run_op(OP_REMU, 32'h12345678, 32'd0,        5'd11, 1'b0);
    run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd12, 1'b0);
    run_op(OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd13, 1'b0);
    run_op(OP_DIV,  32'h80000000, 32'd1,        5'd14, 1'b0);
    run_op(OP_REM,  32'h80000000, 32'hFFFFFFFD, 5'd15, 1'b0);
    run_op(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd16, 1'b0);

    // Flush on CALC cycle 10 kills the operation.
    bus.op_i = OP_DIV; bus.dividend_i = 32'd1000; bus.divisor_i = 32'd7;
    bus.rd_addr_i = 5'd3; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_stall", 32'(bus.stall_o), 32'd0);
    check("flush_valid", 32'(bus.valid_o), 32'd0);
    run_op(OP_DIVU, 32'd9, 32'd3, 5'd7, 1'b0);

    // Flush beats a simultaneous start in IDLE.
    bus.op_i = OP_DIV; bus.dividend_i = 32'd50; bus.divisor_i = 32'd5;
    bus.rd_addr_i = 5'd20; bus.start_i = 1'b1; bus.flush_i = 1'b1;
    #1;
    check("flush_start_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    #1;
    check("flush_start_idle", 32'(bus.stall_o), 32'd0);
    check("flush_start_valid", 32'(bus.valid_o), 32'd0);
    check("flush_start_rd", 32'(bus.rd_addr_o), 32'd7);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    bus.op_i = OP_DIV; bus.dividend_i = 32'd77; bus.divisor_i = 32'd7;
    bus.rd_addr_i = 5'd21; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result", bus.result_o, 32'd0);
    check("arst_rd", 32'(bus.rd_addr_o), 32'd0);
    check("arst_valid", 32'(bus.valid_o), 32'd0);
    check("arst_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(OP_REM, 32'd77, 32'd10, 5'd22, 1'b0);

    for (int i = 0; i < 40; i++) rand_op();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage, directly downstream of operand forwarding, and consumes the forwarded rs1/rs2 values.
- Holds the pipeline with a stall request while it computes.
- Delivers a one-cycle-valid result tagged with the destination register address.

Parameters:
- XLEN, 32 (from `XLEN in defines.v), operand and result width.

Ports:
- clk  in  1  Pipeline clock.
- rst_n  in  1  Reset; asynchronous, active-low.
- start_i  in  1  Divide request from execute decode; sampled only in IDLE.
- op_i  in  2  Operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i  in  XLEN  Forwarded rs1 data.
- divisor_i  in  XLEN  Forwarded rs2 data.
- rd_addr_i  in  5  Destination register of the divide instruction.
- flush_i  in  1  Synchronous kill from pipeline control (branch/trap).
- result_o  out  XLEN  Quotient or remainder.
- rd_addr_o  out  5  Destination register captured at start.
- valid_o  out  1  result_o/rd_addr_o valid; one-cycle pulse.
- stall_o  out  1  Stall request to pipeline control.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; result_o, rd_addr_o, valid_o, counter and working registers all 0. stall_o is then 0.
- State machine: IDLE, CALC, DONE.
- IDLE, start_i=1, flush_i=0: capture op_i and rd_addr_i, then branch on operands.
  - Divisor zero: next state DONE. Result: DIV/DIVU all-ones; REM/REMU the dividend.
  - Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): next state DONE. Result: DIV 0x80000000; REM 0.
  - Otherwise: load |dividend| and |divisor| (absolute value only for signed ops), clear the partial remainder, counter=0, next state CALC.
  - Record the quotient-negate flag (sign(dividend) XOR sign(divisor)) and the remainder-negate flag (sign(dividend)); both only for signed ops.
- CALC: one restoring step per clock.
  - Shift {remainder, dividend} left by 1.
  - Trial-subtract the divisor in XLEN+1 bits; keep the difference if non-negative and set the quotient bit to 1.
  - Counter increments each cycle. On the edge with counter = XLEN-1, apply sign correction, register result_o, and go to DONE.
- DONE: valid_o=1 for exactly this cycle; next state IDLE unconditionally.
- Latency:
  - Normal: valid_o is high in the 33rd cycle after the cycle where start_i was accepted.
  - Special cases: valid_o is high in the 1st cycle after.
- stall_o = (IDLE & start_i & ~flush_i) | CALC. It is combinational so the issuing instruction is held from its first cycle. It is low in DONE so the pipeline advances and captures the result.
- Requests are never queued: start_i in CALC or DONE is ignored.
- flush_i=1 in any state: next state IDLE, valid_o=0 next cycle, no result produced. flush_i beats a simultaneous start_i.
- result_o holds its last value outside DONE; consumers qualify it with valid_o only.
- Asynchronous reset mid-CALC aborts immediately to IDLE with all outputs 0.
- Sign correction uses two's complement negation in XLEN bits. |0x80000000| as an unsigned magnitude is handled correctly: no overflow, because the divisor=-1 case is special-cased.

Decomposition:
- Op-encoding constants (DIV/DIVU/REM/REMU codes) and state encodings go in defines.v next to `XLEN.
- One natural sub-module: div_core_step, the combinational shift/trial-subtract/quotient-bit slice instantiated once in CALC.
- Control FSM and sign handling stay in div_unit.

Test Plan:
- DIV 100 / 7, rd=5 -> stall_o high 33 cycles; valid_o pulses once with result_o=14, rd_addr_o=5.
- REM -100 (0xFFFFFF9C) by 7 -> result_o=0xFFFFFFFE (-2); DIV same operands -> 0xFFFFFFF2 (-14).
- DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF; REMU same -> 1.
- DIV 0x12345678 / 0 -> all-ones. REMU 0x12345678 / 0 -> 0x12345678. Both valid in the 1st cycle after start.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0. Both single-cycle.
- Start DIV, assert flush_i on CALC cycle 10 -> no valid_o pulse, stall_o low the next cycle. New DIVU 9/3 accepted immediately and returns 3. Repeat with rst_n pulsed low mid-CALC -> all outputs 0 asynchronously.
